// File: rtl/satatrn_rxsplit_if.sv
// Handshake bundle for the SATA transport RX splitter: inbound link-layer words,
// PHY-clock data payload stream and system-clock register FIS stream.
`timescale 1ns/1ps
interface satatrn_rxsplit_if;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_data;
    logic        i_last;

    logic        o_data_valid;
    logic        i_data_ready;
    logic [31:0] o_data_data;
    logic        o_data_last;

    logic        o_reg_valid;
    logic        i_reg_ready;
    logic [31:0] o_reg_data;
    logic        o_reg_last;

    modport slave (
        input  i_valid, i_data, i_last, i_data_ready, i_reg_ready,
        output o_ready, o_data_valid, o_data_data, o_data_last,
               o_reg_valid, o_reg_data, o_reg_last
    );

    modport master (
        output i_valid, i_data, i_last, i_data_ready, i_reg_ready,
        input  o_ready, o_data_valid, o_data_data, o_data_last,
               o_reg_valid, o_reg_data, o_reg_last
    );
endinterface

// File: rtl/satatrn_rxsplit.sv
// SATA transport RX splitter: data FIS payloads leave on the PHY clock with the header
// stripped; every other FIS crosses whole to the system clock through a gray-code async FIFO.
`timescale 1ns/1ps
module satatrn_rxsplit #(
    parameter int   LGAFIFO      = 4,
    parameter int   MAXDATA      = 2048,
    parameter logic OPT_LOWPOWER = 1'b0
) (
    input  logic                 i_phy_clk,
    input  logic                 i_phy_reset_n,
    input  logic                 i_clk,
    input  logic                 i_reset,
    satatrn_rxsplit_if.slave     bus,
    output logic                 o_drop,
    output logic                 o_overlen
);
    localparam int AW = LGAFIFO;
    localparam int CW = $clog2(MAXDATA + 2);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAXDATA);
    localparam logic [CW-1:0] CNT_SAT = CW'(MAXDATA + 1);
    localparam logic [AW:0]   PTR_ONE = {{AW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_REG  = 2'd2
    } state_t;

    function automatic logic [AW:0] bin2gray(input logic [AW:0] b);
        return b ^ (b >> 1);
    endfunction

    logic [32:0] mem [0:(1<<AW)-1];

    // ---------------- write side (PHY clock) ----------------
    logic [AW:0] wbin_q, wgray_q, wq1_rgray_q, wq2_rgray_q, wbin_d;
    logic [1:0]  wsys_rst_q;
    logic        wflush_s, full_s, fifo_ok_s, fifo_wr_s;

    assign wflush_s  = wsys_rst_q[1];
    assign full_s    = (wgray_q == {~wq2_rgray_q[AW:AW-1], wq2_rgray_q[AW-2:0]});
    assign fifo_ok_s = !full_s && !wflush_s;
    assign wbin_d    = fifo_wr_s ? (wbin_q + PTR_ONE) : wbin_q;

    // A system reset empties the FIFO, so the writer must restart from zero as well
    always_ff @(posedge i_phy_clk or negedge i_phy_reset_n) begin
        if (!i_phy_reset_n) begin
            wsys_rst_q  <= 2'b00;
            wq1_rgray_q <= '0;
            wq2_rgray_q <= '0;
        end else begin
            wsys_rst_q  <= {wsys_rst_q[0], i_reset};
            wq1_rgray_q <= rgray_q;
            wq2_rgray_q <= wq1_rgray_q;
        end
    end

    // Write pointer, binary for addressing and gray for the crossing
    always_ff @(posedge i_phy_clk or negedge i_phy_reset_n) begin
        if (!i_phy_reset_n) begin
            wbin_q  <= '0;
            wgray_q <= '0;
        end else if (wflush_s) begin
            wbin_q  <= '0;
            wgray_q <= '0;
        end else begin
            wbin_q  <= wbin_d;
            wgray_q <= bin2gray(wbin_d);
        end
    end

    // FIFO storage
    always_ff @(posedge i_phy_clk) begin
        if (fifo_wr_s) begin
            mem[wbin_q[AW-1:0]] <= {bus.i_last, bus.i_data};
        end else begin
            mem[wbin_q[AW-1:0]] <= mem[wbin_q[AW-1:0]];
        end
    end

    // ---------------- read side (system clock) ----------------
    logic [AW:0] rbin_q, rgray_q, rq1_wgray_q, rq2_wgray_q, rbin_d;
    logic [1:0]  rphy_rst_q;
    logic        rflush_s, rd_s;
    logic [32:0] rd_word_s;

    // PHY reset clears the reader at once and holds it for two cycles after release
    always_ff @(posedge i_clk or negedge i_phy_reset_n) begin
        if (!i_phy_reset_n) begin
            rphy_rst_q <= 2'b00;
        end else begin
            rphy_rst_q <= {rphy_rst_q[0], 1'b1};
        end
    end

    assign rflush_s        = i_reset || !rphy_rst_q[1];
    assign bus.o_reg_valid = !rflush_s && (rgray_q != rq2_wgray_q);
    assign rd_s            = bus.o_reg_valid && bus.i_reg_ready;
    assign rbin_d          = rd_s ? (rbin_q + PTR_ONE) : rbin_q;
    assign rd_word_s       = mem[rbin_q[AW-1:0]];
    assign bus.o_reg_data  = rd_word_s[31:0];
    assign bus.o_reg_last  = rd_word_s[32];

    // Read pointer and write-pointer synchroniser
    always_ff @(posedge i_clk or negedge i_phy_reset_n) begin
        if (!i_phy_reset_n) begin
            rbin_q      <= '0;
            rgray_q     <= '0;
            rq1_wgray_q <= '0;
            rq2_wgray_q <= '0;
        end else if (rflush_s) begin
            rbin_q      <= '0;
            rgray_q     <= '0;
            rq1_wgray_q <= wgray_q;
            rq2_wgray_q <= rq1_wgray_q;
        end else begin
            rbin_q      <= rbin_d;
            rgray_q     <= bin2gray(rbin_d);
            rq1_wgray_q <= wgray_q;
            rq2_wgray_q <= rq1_wgray_q;
        end
    end

    // ---------------- classifier FSM (PHY clock) ----------------
    state_t      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        dvalid_q, dvalid_d, dlast_q, dlast_d;
    logic [31:0] ddata_q, ddata_d;
    logic        drop_q, drop_d, overlen_q, overlen_d;
    logic        ready_s, room_s, load_s;

    assign room_s = !dvalid_q || bus.i_data_ready;

    // Next-state, handshake and write-enable decode
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ready_s   = 1'b0;
        fifo_wr_s = 1'b0;
        load_s    = 1'b0;
        drop_d    = 1'b0;
        overlen_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.i_valid && (bus.i_data[7:0] == 8'h46)) begin
                    ready_s = 1'b1;
                    if (bus.i_last) begin
                        drop_d = 1'b1;
                    end else begin
                        state_d = ST_DATA;
                        cnt_d   = '0;
                    end
                end else if (bus.i_valid) begin
                    ready_s   = fifo_ok_s;
                    fifo_wr_s = fifo_ok_s;
                    if (fifo_ok_s && !bus.i_last) begin
                        state_d = ST_REG;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DATA: begin
                ready_s = room_s;
                if (bus.i_valid && room_s) begin
                    load_s    = 1'b1;
                    cnt_d     = (cnt_q == CNT_SAT) ? cnt_q : (cnt_q + {{(CW-1){1'b0}}, 1'b1});
                    overlen_d = (cnt_q == CNT_MAX);
                    if (bus.i_last) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_REG: begin
                ready_s   = fifo_ok_s;
                fifo_wr_s = bus.i_valid && fifo_ok_s;
                if (fifo_wr_s && bus.i_last) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_REG;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Payload output register follows AXI-stream hold rules
    always_comb begin
        dvalid_d = dvalid_q;
        ddata_d  = ddata_q;
        dlast_d  = dlast_q;
        if (load_s) begin
            dvalid_d = 1'b1;
            ddata_d  = bus.i_data;
            dlast_d  = bus.i_last;
        end else if (bus.i_data_ready) begin
            dvalid_d = 1'b0;
            if (OPT_LOWPOWER) begin
                ddata_d = 32'h0000_0000;
                dlast_d = 1'b0;
            end else begin
                ddata_d = ddata_q;
                dlast_d = dlast_q;
            end
        end else begin
            dvalid_d = dvalid_q;
        end
    end

    // PHY-domain state registers
    always_ff @(posedge i_phy_clk or negedge i_phy_reset_n) begin
        if (!i_phy_reset_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            dvalid_q  <= 1'b0;
            ddata_q   <= 32'h0000_0000;
            dlast_q   <= 1'b0;
            drop_q    <= 1'b0;
            overlen_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dvalid_q  <= dvalid_d;
            ddata_q   <= ddata_d;
            dlast_q   <= dlast_d;
            drop_q    <= drop_d;
            overlen_q <= overlen_d;
        end
    end

    assign bus.o_ready        = ready_s;
    assign bus.o_data_valid   = dvalid_q;
    assign bus.o_data_data    = ddata_q;
    assign bus.o_data_last    = dlast_q;
    assign o_drop             = drop_q;
    assign o_overlen          = overlen_q;
endmodule
